// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: one character per ready/valid handshake,
// framed as start, DATA_BITS data (LSB first), optional parity, 1-2 stop bits.
module uart_tx_param #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_out,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST  = BIT_W'(STOP_BITS - 1);
  localparam bit                HAS_PARITY = (PARITY != 0);
  localparam bit                ODD_PARITY = (PARITY == 2);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  function automatic logic parity_bit(input logic [DATA_BITS-1:0] data,
                                      input logic                 odd);
    return (^data) ^ odd;
  endfunction

  state_e               state_q,  state_d;
  logic [BAUD_W-1:0]    baud_q,   baud_d;
  logic [BIT_W-1:0]     bit_q,    bit_d;
  logic [DATA_BITS-1:0] shift_q,  shift_d;
  logic                 parity_q, parity_d;
  logic                 tx_out_q, tx_out_d;
  logic                 tx_ready_q, tx_ready_d;
  logic                 busy_q,   busy_d;
  logic                 tx_done_q, tx_done_d;

  logic baud_last;
  logic accept;

  assign baud_last = (baud_q == BAUD_LAST);
  assign accept    = tx_valid && tx_ready_q;

  // Next-state, counter and shift-register logic.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;

    if (state_q == ST_IDLE) begin
      baud_d = '0;
    end else if (baud_last) begin
      baud_d = '0;
    end else begin
      baud_d = baud_q + BAUD_W'(1'b1);
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d  = ST_START;
          shift_d  = tx_data;
          parity_d = parity_bit(tx_data, ODD_PARITY);
          bit_d    = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (baud_last) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (baud_last) begin
          shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = HAS_PARITY ? ST_PARITY : ST_STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1'b1);
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (baud_last) begin
          state_d = ST_STOP;
        end else begin
          state_d = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (baud_last) begin
          if (bit_q == STOP_LAST) begin
            bit_d   = '0;
            state_d = ST_IDLE;
          end else begin
            bit_d = bit_q + BIT_W'(1'b1);
          end
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        bit_d   = '0;
      end
    endcase
  end

  // Output flops are loaded from the current state, so the line trails the
  // state machine by one cycle and leaves one idle cycle after each accept.
  always_comb begin
    tx_out_d = 1'b1;
    case (state_q)
      ST_IDLE:   tx_out_d = 1'b1;
      ST_START:  tx_out_d = 1'b0;
      ST_DATA:   tx_out_d = shift_q[0];
      ST_PARITY: tx_out_d = parity_q;
      ST_STOP:   tx_out_d = 1'b1;
      default:   tx_out_d = 1'b1;
    endcase

    tx_done_d  = (state_q == ST_STOP) && baud_last && (bit_q == STOP_LAST);
    tx_ready_d = (state_d == ST_IDLE);
    busy_d     = (state_d != ST_IDLE) || tx_done_d;
  end

  // State, counters and registered outputs; reset forces the line high at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      tx_out_q   <= 1'b1;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      tx_out_q   <= tx_out_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
      tx_done_q  <= tx_done_d;
    end
  end

  assign tx_out   = tx_out_q;
  assign tx_ready = tx_ready_q;
  assign busy     = busy_q;
  assign tx_done  = tx_done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: five configurations side by side, each frame checked
// cycle by cycle against a bit-list model of the serial line.
module tb_uart_tx_param;

  localparam int NU = 5;
  localparam int CPB [NU] = '{4, 4, 4, 4, 2};
  localparam int DB  [NU] = '{8, 8, 8, 7, 9};
  localparam int PM  [NU] = '{0, 1, 2, 0, 1};
  localparam int SB  [NU] = '{1, 1, 1, 2, 2};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NU-1:0]      tx_valid_a;
  logic [NU-1:0]      tx_ready_a;
  logic [NU-1:0]      tx_out_a;
  logic [NU-1:0]      busy_a;
  logic [NU-1:0]      tx_done_a;
  logic [NU-1:0][8:0] tx_data_a;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NU; g++) begin : g_dut
    uart_tx_param #(
      .CLKS_PER_BIT(CPB[g]),
      .DATA_BITS   (DB[g]),
      .PARITY      (PM[g]),
      .STOP_BITS   (SB[g])
    ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .tx_data (tx_data_a[g][DB[g]-1:0]),
      .tx_valid(tx_valid_a[g]),
      .tx_ready(tx_ready_a[g]),
      .tx_out  (tx_out_a[g]),
      .busy    (busy_a[g]),
      .tx_done (tx_done_a[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int frame_len(input int u);
    return CPB[u] * (1 + DB[u] + ((PM[u] != 0) ? 1 : 0) + SB[u]);
  endfunction

  // Expected line level t cycles after the accept edge (t = 1..F).
  function automatic logic model_line(input int u, input logic [8:0] d, input int t);
    int j;
    int ones;
    j = (t - 1) / CPB[u];
    ones = 0;
    for (int i = 0; i < DB[u]; i++) ones += int'(d[i]);
    if (j == 0) return 1'b0;
    if (j <= DB[u]) return d[j-1];
    if (PM[u] != 0 && j == DB[u] + 1) return (PM[u] == 1) ? ((ones % 2) == 1) : ((ones % 2) == 0);
    return 1'b1;
  endfunction

  task automatic accept(input int u, input logic [8:0] d);
    int waited;
    waited = 0;
    tx_valid_a[u] = 1'b1;
    tx_data_a[u]  = d;
    while (tx_ready_a[u] !== 1'b1 && waited < 200) begin
      tick();
      waited++;
    end
    check($sformatf("u%0d ready_wait", u), 32'(waited < 200), 32'd1);
    tick();
    check($sformatf("u%0d accept_ready", u), 32'(tx_ready_a[u]), 32'd0);
    check($sformatf("u%0d accept_busy", u), 32'(busy_a[u]), 32'd1);
    check($sformatf("u%0d accept_line", u), 32'(tx_out_a[u]), 32'd1);
    check($sformatf("u%0d accept_done", u), 32'(tx_done_a[u]), 32'd0);
  endtask

  task automatic run_frame(input int u, input logic [8:0] d, input bit hold,
                           input logic [8:0] nd, input int pulse_at, input int abort_at);
    int f;
    f = frame_len(u);
    if (hold) begin
      tx_data_a[u] = nd;
    end else begin
      tx_valid_a[u] = 1'b0;
      tx_data_a[u]  = 9'($urandom);
    end
    for (int t = 1; t <= f; t++) begin
      if (t == pulse_at) begin
        tx_valid_a[u] = 1'b1;
        tx_data_a[u]  = 9'($urandom);
      end
      if (t == pulse_at + 1) tx_valid_a[u] = 1'b0;
      tick();
      check($sformatf("u%0d line t=%0d", u, t), 32'(tx_out_a[u]), 32'(model_line(u, d, t)));
      check($sformatf("u%0d done t=%0d", u, t), 32'(tx_done_a[u]), 32'(t == f));
      if (t < f) check($sformatf("u%0d ready t=%0d", u, t), 32'(tx_ready_a[u]), 32'd0);
      if (t == abort_at) begin
        rst = 1'b1;
        tx_valid_a[u] = 1'b0;
        #1;
        check($sformatf("u%0d abort_line", u), 32'(tx_out_a[u]), 32'd1);
        check($sformatf("u%0d abort_done", u), 32'(tx_done_a[u]), 32'd0);
        for (int r = 0; r < 2; r++) begin
          tick();
          check($sformatf("u%0d rst_done", u), 32'(tx_done_a[u]), 32'd0);
          check($sformatf("u%0d rst_line", u), 32'(tx_out_a[u]), 32'd1);
        end
        rst = 1'b0;
        tick();
        check($sformatf("u%0d post_rst_ready", u), 32'(tx_ready_a[u]), 32'd1);
        check($sformatf("u%0d post_rst_busy", u), 32'(busy_a[u]), 32'd0);
        check($sformatf("u%0d post_rst_done", u), 32'(tx_done_a[u]), 32'd0);
        check($sformatf("u%0d post_rst_line", u), 32'(tx_out_a[u]), 32'd1);
        return;
      end
    end
    tick();
    if (hold) begin
      // Second accept must land exactly F+1 cycles after the first.
      check($sformatf("u%0d b2b_ready", u), 32'(tx_ready_a[u]), 32'd0);
      check($sformatf("u%0d b2b_busy", u), 32'(busy_a[u]), 32'd1);
      check($sformatf("u%0d b2b_gap_line", u), 32'(tx_out_a[u]), 32'd1);
      check($sformatf("u%0d b2b_done", u), 32'(tx_done_a[u]), 32'd0);
    end else begin
      check($sformatf("u%0d end_ready", u), 32'(tx_ready_a[u]), 32'd1);
      check($sformatf("u%0d end_busy", u), 32'(busy_a[u]), 32'd0);
      check($sformatf("u%0d end_done", u), 32'(tx_done_a[u]), 32'd0);
      check($sformatf("u%0d end_line", u), 32'(tx_out_a[u]), 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int u;
    int gap;
    logic [8:0] d;
    logic [8:0] nd;

    tx_valid_a = '0;
    tx_data_a  = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NU; i++) begin
      check($sformatf("u%0d rst_ready", i), 32'(tx_ready_a[i]), 32'd1);
      check($sformatf("u%0d rst_line", i), 32'(tx_out_a[i]), 32'd1);
      check($sformatf("u%0d rst_busy", i), 32'(busy_a[i]), 32'd0);
      check($sformatf("u%0d rst_done", i), 32'(tx_done_a[i]), 32'd0);
    end
    rst = 1'b0;
    tick();

    // 8N1, 8E1, 8O1 and 7N2 directed frames.
    accept(0, 9'h0A5); run_frame(0, 9'h0A5, 1'b0, 9'h000, -1, -1);
    accept(1, 9'h0A5); run_frame(1, 9'h0A5, 1'b0, 9'h000, -1, -1);
    accept(2, 9'h0A5); run_frame(2, 9'h0A5, 1'b0, 9'h000, -1, -1);
    accept(1, 9'h001); run_frame(1, 9'h001, 1'b0, 9'h000, -1, -1);
    accept(3, 9'h0D5); run_frame(3, 9'h0D5, 1'b0, 9'h000, -1, -1);

    // Back-to-back with tx_data changed mid-frame.
    accept(0, 9'h03C);
    run_frame(0, 9'h03C, 1'b1, 9'h0C3, -1, -1);
    run_frame(0, 9'h0C3, 1'b0, 9'h000, -1, -1);

    // tx_valid pulsed while busy must be ignored.
    accept(2, 9'h05A);
    run_frame(2, 9'h05A, 1'b0, 9'h000, 9, -1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("u2 no_accept_ready", 32'(tx_ready_a[2]), 32'd1);
      check("u2 no_accept_line", 32'(tx_out_a[2]), 32'd1);
    end

    // Reset during data bit 3, then a clean frame.
    accept(0, 9'h0A5);
    run_frame(0, 9'h0A5, 1'b0, 9'h000, -1, 18);
    accept(0, 9'h081);
    run_frame(0, 9'h081, 1'b0, 9'h000, -1, -1);

    // Random frames across all configurations.
    for (int n = 0; n < 14; n++) begin
      u   = int'($urandom_range(0, NU - 1));
      d   = 9'($urandom);
      gap = int'($urandom_range(0, 3));
      for (int i = 0; i < gap; i++) begin
        tx_data_a[u] = 9'($urandom);
        tick();
        check($sformatf("u%0d idle_line", u), 32'(tx_out_a[u]), 32'd1);
        check($sformatf("u%0d idle_ready", u), 32'(tx_ready_a[u]), 32'd1);
      end
      accept(u, d);
      if ($urandom_range(0, 1) == 1) begin
        nd = 9'($urandom);
        run_frame(u, d, 1'b1, nd, -1, -1);
        run_frame(u, nd, 1'b0, 9'h000, -1, -1);
      end else begin
        run_frame(u, d, 1'b0, 9'h000, -1, -1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
# uart_tx_param

Parametrised UART transmitter that serialises one character per ready/valid handshake onto a single idle-high line. Baud divisor, data width, parity mode and stop-bit count are set by parameters. It sits between the byte-producing controller logic and the board TX pin, and it is the configurable successor to the team's fixed 8N1 transmitter.

## Interface
- CLKS_PER_BIT, default 16: clk cycles per serial bit. Must be ≥ 2.
- DATA_BITS, default 8: data bits per frame. Legal range 5–9.
- PARITY, default 0: parity mode. 0 = none, 1 = even, 2 = odd.
- STOP_BITS, default 1: number of stop bits. Legal values 1 or 2.

- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- tx_data  input  DATA_BITS  character to send. Sampled only on the accept cycle.
- tx_valid  input  1  producer has a character on tx_data.
- tx_ready  output  1  block can accept a character. Registered.
- tx_out  output  1  serial line, idle high. Registered.
- busy  output  1  high from the cycle after accept until the frame completes.
- tx_done  output  1  one-cycle pulse marking frame completion.

## Operation
- State machine: IDLE → START → DATA → PARITY → STOP → IDLE.
  - PARITY is skipped when PARITY=0.
- IDLE:
  - tx_out=1, tx_ready=1, busy=0.
  - Accept occurs on any cycle with tx_valid && tx_ready. On accept:
    - latch tx_data into the shift register;
    - compute the parity bit: even = XOR of data bits; odd = inverted XOR;
    - clear the bit and baud counters;
    - drop tx_ready;
    - move to START.
- START: tx_out=0 for CLKS_PER_BIT cycles.
- DATA:
  - Sends DATA_BITS bits, LSB first, each for CLKS_PER_BIT cycles.
  - The bit counter is $clog2(DATA_BITS+1) bits wide.
- PARITY: sends the latched parity bit for CLKS_PER_BIT cycles.
- STOP:
  - tx_out=1 for STOP_BITS×CLKS_PER_BIT cycles.
  - tx_done=1 on the last cycle of the final stop bit.
  - The next state is IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and is $clog2(CLKS_PER_BIT) bits wide.
  - Wraps to 0 at each bit boundary.
  - The bit advances when the counter reaches CLKS_PER_BIT-1.
- Held inputs: tx_valid and tx_data are ignored while tx_ready=0. There is no queuing; the producer must hold tx_valid until it sees tx_ready.
- tx_data is latched at accept, so changes during a frame have no effect on it.
- Reset values: tx_out=1, tx_ready=1, busy=0, tx_done=0, state=IDLE, all counters 0.
- Reset mid-frame:
  - tx_out goes high immediately (asynchronously) and the frame is abandoned.
  - No tx_done is produced.
  - tx_ready=1 on the first clock after rst deasserts.

## Timing
- Frame length: F = CLKS_PER_BIT×(1 + DATA_BITS + (PARITY≠0) + STOP_BITS) cycles.
- Accept at edge k (tx_valid && tx_ready sampled high):
  - tx_ready=0 and busy=1 from edge k;
  - the start bit appears on tx_out from edge k+1;
  - the line starts its low level at cycle k+1.
- Bit j of the frame (start = 0) occupies cycles k+1+j×CLKS_PER_BIT through k+(j+1)×CLKS_PER_BIT.
- Frame end:
  - tx_done is high during cycle k+F;
  - at edge k+F+1, state=IDLE, tx_ready=1, busy=0, tx_done=0.
- Back-to-back: if tx_valid is held, the next accept happens at edge k+F+1 and the next start bit at k+F+2.
  - Minimum character period is F+1 cycles, including one idle-high cycle between frames.
- tx_out never glitches: it changes only on clk edges, or on rst assertion.

## Test plan
- **8N1 basic.** CLKS_PER_BIT=4, DATA_BITS=8, PARITY=0, STOP_BITS=1; send 0xA5.
  - tx_out must be 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 total).
  - tx_done pulses exactly once, in the final cycle.
- **Parity modes.** 8E1 send 0xA5 → parity bit 0; 8O1 send 0xA5 → parity bit 1; 8E1 send 0x01 → parity bit 1.
  - Frame length is 44 cycles at CLKS_PER_BIT=4.
- **7 data bits, 2 stop bits, no parity.** Send 0x55.
  - Line must read start 0, then 1,0,1,0,1,0,1, then two stop bits of 1 (10 bits, 40 cycles).
  - Bit 7 of tx_data is ignored.
- **Back-to-back.** Hold tx_valid with 0x3C, then 0xC3.
  - Second accept occurs exactly F+1 cycles after the first.
  - Exactly one idle-high cycle separates the frames.
  - Changing tx_data mid-frame does not alter the first frame.
- **Reset mid-frame.** Assert rst during data bit 3.
  - tx_out=1 immediately; no tx_done.
  - After release: tx_ready=1, and a fresh 0x81 frame transmits correctly.
- **Handshake.** Pulse tx_valid while busy=1.
  - Nothing is accepted and the line is undisturbed.
  - tx_ready stays 0 until the frame ends.
